// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: operand capture, load-use bubble, flush, stall counter.
// Optional WB_BYPASS_EN forwards the WB write data into the captured operands.
module id_ex_stage #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned CTRL_WIDTH      = 8,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [XLEN-1:0]            id_pc,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rd_addr,
  input  logic                       id_uses_rs1,
  input  logic                       id_uses_rs2,
  input  logic [XLEN-1:0]            id_imm,
  input  logic [CTRL_WIDTH-1:0]      id_ctrl,
  input  logic                       id_mem_read,
  input  logic                       id_reg_write,
  input  logic [XLEN-1:0]            rf_data_rs1,
  input  logic [XLEN-1:0]            rf_data_rs2,
  input  logic                       wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]            wb_rd_data,
  input  logic                       flush_ex,
  output logic                       stall_id,
  output logic                       ex_valid,
  output logic [XLEN-1:0]            ex_pc,
  output logic [XLEN-1:0]            ex_imm,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr,
  output logic [XLEN-1:0]            ex_rs1_data,
  output logic [XLEN-1:0]            ex_rs2_data,
  output logic [CTRL_WIDTH-1:0]      ex_ctrl,
  output logic                       ex_mem_read,
  output logic                       ex_reg_write,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  logic            load_use;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;

  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
  end

  assign stall_id = load_use && !flush_ex;

  always_comb begin
    rs1_sel = (id_rs1_addr == '0) ? '0 : rf_data_rs1;
    rs2_sel = (id_rs2_addr == '0) ? '0 : rf_data_rs2;
`ifdef WB_BYPASS_EN
    // wb_rd_addr != 0 already excludes x0, so the zero forcing above stays intact
    if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr))
      rs1_sel = wb_rd_data;
    if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr))
      rs2_sel = wb_rd_data;
`endif
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd_addr, wb_rd_data};
`endif

  always_ff @(posedge clk) begin
    if (rst || flush_ex || load_use) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_rs1_data  <= rs1_sel;
      ex_rs2_data  <= rs2_sel;
      ex_ctrl      <= id_ctrl;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_reg_write <= id_reg_write && id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_id && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
